axis_insert_header_v2: RTL



---
 rtl/axis_hdr_pkg.sv | 26 ++
 rtl/axis_byte_shift.sv | 27 ++
 rtl/axis_insert_header_v2.sv | 124 ++++++++++++
 3 files changed

// File: rtl/axis_hdr_pkg.sv
// rtl/axis_hdr_pkg.sv - shared state type, byte constants and keep helpers for the header inserter
package axis_hdr_pkg;

  localparam int BYTE_WD     = 8;
  localparam int MAX_KEEP_WD = 128;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  function automatic int popcount(input logic [MAX_KEEP_WD-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEEP_WD; i++) n += int'(keep[i]);
    return n;
  endfunction

  // n ones at the top of a width-bit keep field
  function automatic logic [MAX_KEEP_WD-1:0] keep_top(input int n, input int width);
    logic [MAX_KEEP_WD-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KEEP_WD; i++) begin
      if (i < width && i >= width - n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_byte_shift.sv
// rtl/axis_byte_shift.sv - merges the hold residue with payload bytes into one output beat
module axis_byte_shift
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD = 32
) (
  input  logic [DATA_WD-1:0]         hold,
  input  logic [DATA_WD-1:0]         data,
  input  logic [$clog2(DATA_WD/8):0] hcnt,
  output logic [DATA_WD-1:0]         word,
  output logic [DATA_WD-1:0]         next_hold
);

  localparam int B = DATA_WD / BYTE_WD;

  int sh_out;
  int sh_hold;

  // hold is left-aligned with zero bytes below hcnt, so an OR is enough to merge
  always_comb begin
    sh_out    = int'(hcnt) * BYTE_WD;
    sh_hold   = (B - int'(hcnt)) * BYTE_WD;
    word      = hold | (data >> sh_out);
    next_hold = data << sh_hold;
  end

endmodule

// File: rtl/axis_insert_header_v2.sv
// rtl/axis_insert_header_v2.sv - prepends a 0..B byte header to an AXI-Stream payload packet
module axis_insert_header_v2
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_WD / 8) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert
);

  state_t                  state, state_nxt;
  logic [DATA_WD-1:0]      hold, hold_nxt;
  logic [BYTE_CNT_WD-1:0]  hcnt, hcnt_nxt;
  logic [DATA_WD-1:0]      data_mask, data_valid;
  logic [DATA_WD-1:0]      shift_word, shift_hold;
  logic [DATA_BYTE_WD-1:0] keep_sum, keep_tail;
  int                      hdr_bytes, last_bytes, sum_bytes;

  always_comb begin
    data_mask = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) data_mask[i*BYTE_WD +: BYTE_WD] = {BYTE_WD{keep_in[i]}};
  end

  assign data_valid = data_in & data_mask;

  axis_byte_shift #(.DATA_WD(DATA_WD)) u_byte_shift (
    .hold      (hold),
    .data      (data_valid),
    .hcnt      (hcnt),
    .word      (shift_word),
    .next_hold (shift_hold)
  );

  always_comb begin
    hdr_bytes  = popcount(MAX_KEEP_WD'(keep_insert));
    last_bytes = popcount(MAX_KEEP_WD'(keep_in));
    sum_bytes  = int'(hcnt) + last_bytes;
    keep_sum   = DATA_BYTE_WD'(keep_top(sum_bytes, DATA_BYTE_WD));
    keep_tail  = DATA_BYTE_WD'(keep_top(int'(hcnt), DATA_BYTE_WD));
  end

  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold;
    hcnt_nxt     = hcnt;
    ready_insert = 1'b0;
    ready_in     = 1'b0;
    valid_out    = 1'b0;
    data_out     = '0;
    keep_out     = '0;
    last_out     = 1'b0;
    case (state)
      IDLE: begin
        ready_insert = 1'b1;
        if (valid_insert) begin
          hold_nxt  = data_insert << ((DATA_BYTE_WD - hdr_bytes) * BYTE_WD);
          hcnt_nxt  = BYTE_CNT_WD'(hdr_bytes);
          state_nxt = DATA;
        end
      end
      DATA: begin
        ready_in  = ready_out;
        valid_out = valid_in;
        if (valid_in) begin
          data_out = shift_word;
          keep_out = '1;
          if (last_in && sum_bytes <= DATA_BYTE_WD) begin
            keep_out = keep_sum;
            last_out = 1'b1;
          end
          if (ready_out) begin
            hold_nxt = shift_hold;
            if (last_in) begin
              if (sum_bytes <= DATA_BYTE_WD) begin
                state_nxt = IDLE;
              end else begin
                // hcnt now counts the residual bytes the tail beat must carry
                hcnt_nxt  = BYTE_CNT_WD'(sum_bytes - DATA_BYTE_WD);
                state_nxt = TAIL;
              end
            end
          end
        end
      end
      TAIL: begin
        valid_out = 1'b1;
        data_out  = hold;
        keep_out  = keep_tail;
        last_out  = 1'b1;
        if (ready_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

endmodule
